// File: rtl/adc_reader_if.sv
// Pin and user-side signal bundle for the parallel ADC read controller.
interface adc_reader_if;
    logic       start;
    logic       auto_en;
    logic       adc_intn;
    logic [7:0] adc_d;
    logic       adc_csn;
    logic       adc_wrn;
    logic       adc_rdn;
    logic [7:0] data_out;
    logic       data_valid;
    logic       busy;
    logic       timeout_err;
    logic [7:0] led_out;

    // Board/user side: drives requests and the ADC pins, observes results.
    modport master (
        output start, auto_en, adc_intn, adc_d,
        input  adc_csn, adc_wrn, adc_rdn, data_out, data_valid, busy, timeout_err, led_out
    );

    // Controller side.
    modport slave (
        input  start, auto_en, adc_intn, adc_d,
        output adc_csn, adc_wrn, adc_rdn, data_out, data_valid, busy, timeout_err, led_out
    );
endinterface

// File: rtl/adc_reader.sv
// ADC0804-style read controller: start conversion, wait for INTR_n, read the
// data bus and present the sample with a one-cycle valid strobe.
module adc_reader #(
    parameter int unsigned WR_CYC      = 4,
    parameter int unsigned RD_CYC      = 4,
    parameter int unsigned TIMEOUT_CYC = 2000,
    parameter int unsigned PERIOD_CYC  = 5000
) (
    input  logic         clk,
    input  logic         rst,
    adc_reader_if.slave  bus
);

    localparam int unsigned CNT_MAX = (TIMEOUT_CYC > WR_CYC)
                                    ? ((TIMEOUT_CYC > RD_CYC) ? TIMEOUT_CYC : RD_CYC)
                                    : ((WR_CYC > RD_CYC) ? WR_CYC : RD_CYC);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned PER_W   = $clog2(PERIOD_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_WAIT = 3'd2,
        S_RD   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PER_W-1:0]   per_q, per_d;
    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic               csn_q, csn_d;
    logic               wrn_q, wrn_d;
    logic               rdn_q, rdn_d;
    logic               busy_q, busy_d;
    logic [7:0]         data_q, data_d;
    logic               valid_q, valid_d;
    logic               terr_q, terr_d;
    logic [7:0]         led_q, led_d;
    logic               tick_c;
    logic               int_s;

    assign int_s = sync2_q;

    // Synchronizer and period counter next values; tick fires on the wrap.
    always_comb begin
        sync1_d = bus.adc_intn;
        sync2_d = sync1_q;
        tick_c  = bus.auto_en && (per_q == PER_W'(PERIOD_CYC - 1));
        per_d   = '0;
        if (bus.auto_en) begin
            per_d = tick_c ? '0 : per_q + PER_W'(1);
        end
    end

    // FSM state register and shared phase counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; one conversion per IDLE exit even if start and tick coincide.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (bus.start || tick_c) state_d = S_WR;
            end
            S_WR: begin
                if (cnt_q == CNT_W'(WR_CYC - 1)) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (!int_s) begin
                    state_d = S_RD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RD: begin
                if (cnt_q == CNT_W'(RD_CYC - 1)) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output values for the next cycle, decoded from the upcoming state so pins are glitch-free.
    always_comb begin
        csn_d   = !((state_d == S_WR) || (state_d == S_RD));
        wrn_d   = (state_d != S_WR);
        rdn_d   = (state_d != S_RD);
        busy_d  = (state_d != S_IDLE);
        data_d  = data_q;
        valid_d = 1'b0;
        terr_d  = terr_q;
        if ((state_q == S_RD) && (state_d == S_DONE)) begin
            data_d  = bus.adc_d;
            valid_d = 1'b1;
        end
        if ((state_q == S_WAIT) && (state_d == S_IDLE)) begin
            terr_d = 1'b1;
        end
        led_d = data_d;
    end

    // Registered outputs, synchronizer and period counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_q   <= '0;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            csn_q   <= 1'b1;
            wrn_q   <= 1'b1;
            rdn_q   <= 1'b1;
            busy_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            terr_q  <= 1'b0;
            led_q   <= '0;
        end else begin
            per_q   <= per_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            csn_q   <= csn_d;
            wrn_q   <= wrn_d;
            rdn_q   <= rdn_d;
            busy_q  <= busy_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            terr_q  <= terr_d;
            led_q   <= led_d;
        end
    end

    assign bus.adc_csn     = csn_q;
    assign bus.adc_wrn     = wrn_q;
    assign bus.adc_rdn     = rdn_q;
    assign bus.busy        = busy_q;
    assign bus.data_out    = data_q;
    assign bus.data_valid  = valid_q;
    assign bus.timeout_err = terr_q;
    assign bus.led_out     = led_q;

endmodule
